mac_seq_ctrl: RTL and testbench

Sequences one mac_beh-style MAC through dot-product jobs.
- A command gives length N and a bias. The block loads the bias into the MAC, then streams N operand pairs via valid/ready.
- It gates the MAC operands to zero when no beat transfers. The MAC has no enable and accumulates every cycle.
- It captures the final accumulator and presents it on a result handshake.
- It sits between the MPU operand feeder and one MAC unit.

---
 rtl/mac_seq_ctrl_pkg.sv | 17 +
 rtl/mac_beh.sv | 31 +++
 rtl/mac_seq_unit.sv | 73 +++++++
 rtl/mac_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared types and default widths for the MAC sequencer.
// Holds the controller state enum and the default parameter values.
package mac_seq_ctrl_pkg;

    localparam int VAR_SIZE_DEF = 8;
    localparam int ACC_SIZE_DEF = 32;
    localparam int LEN_W_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        BIAS = 3'd1,
        ACC  = 3'd2,
        CAP  = 3'd3,
        OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_beh.sv
// mac_beh: behavioural multiply-accumulate unit with no enable.
// Ports: clk, rst_n (sync, loads bias), a/b signed operands,
//        bias signed initial value, acc signed running sum.
// acc <= acc + sext(a*b) every cycle; two's-complement wrap.
module mac_beh #(
    parameter int VAR_SIZE = 8,
    parameter int ACC_SIZE = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VAR_SIZE-1:0] a,
    input  logic [VAR_SIZE-1:0] b,
    input  logic [ACC_SIZE-1:0] bias,
    output logic [ACC_SIZE-1:0] acc
);

    logic signed [2*VAR_SIZE-1:0] prod;
    logic signed [ACC_SIZE-1:0]   prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = ACC_SIZE'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= bias;
        end else begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/mac_seq_unit.sv
// mac_seq_unit: mac_seq_ctrl plus one mac_beh, MAC reset tied to ~mac_load.
// Ports: clk, rst (sync, high); cmd_*, in_*, out_* handshakes; busy.
module mac_seq_unit
    import mac_seq_ctrl_pkg::*;
#(
    parameter int VAR_SIZE = VAR_SIZE_DEF,
    parameter int ACC_SIZE = ACC_SIZE_DEF,
    parameter int LEN_W    = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [ACC_SIZE-1:0] cmd_bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VAR_SIZE-1:0] in_a,
    input  logic [VAR_SIZE-1:0] in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_SIZE-1:0] out_data,
    output logic                busy
);

    logic [VAR_SIZE-1:0] mac_a;
    logic [VAR_SIZE-1:0] mac_b;
    logic [ACC_SIZE-1:0] mac_bias;
    logic [ACC_SIZE-1:0] mac_acc;
    logic                mac_load;
    logic                mac_rst_n;

    assign mac_rst_n = ~mac_load;

    mac_seq_ctrl #(
        .VAR_SIZE(VAR_SIZE),
        .ACC_SIZE(ACC_SIZE),
        .LEN_W   (LEN_W)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .cmd_bias (cmd_bias),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_bias (mac_bias),
        .mac_load (mac_load),
        .mac_acc  (mac_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    mac_beh #(
        .VAR_SIZE(VAR_SIZE),
        .ACC_SIZE(ACC_SIZE)
    ) u_mac (
        .clk  (clk),
        .rst_n(mac_rst_n),
        .a    (mac_a),
        .b    (mac_b),
        .bias (mac_bias),
        .acc  (mac_acc)
    );

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one MAC through dot-product jobs.
// Ports: cmd_* job command handshake (len, bias); in_* operand beat
//        handshake; mac_* drive/observe the MAC (mac_load = MAC reset);
//        out_* result handshake; busy = not idle. clk, rst (sync, high).
// Optional: define MAC_SEQ_CTRL_RELU_EN to clamp negative results to 0
//           at capture time.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int VAR_SIZE = VAR_SIZE_DEF,
    parameter int ACC_SIZE = ACC_SIZE_DEF,
    parameter int LEN_W    = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [ACC_SIZE-1:0] cmd_bias,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VAR_SIZE-1:0] in_a,
    input  logic [VAR_SIZE-1:0] in_b,
    output logic [VAR_SIZE-1:0] mac_a,
    output logic [VAR_SIZE-1:0] mac_b,
    output logic [ACC_SIZE-1:0] mac_bias,
    output logic                mac_load,
    input  logic [ACC_SIZE-1:0] mac_acc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_SIZE-1:0] out_data,
    output logic                busy
);

    state_t state;
    state_t state_nx;

    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    rem;
    logic [ACC_SIZE-1:0] bias_q;
    logic [ACC_SIZE-1:0] res_q;
    logic [ACC_SIZE-1:0] cap_val;
    logic                cmd_fire;
    logic                beat;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign beat     = in_valid && in_ready;

    // The MAC accumulates every cycle, so operands are zeroed
    // whenever no beat transfers to keep acc unchanged.
    assign mac_a    = beat ? in_a : '0;
    assign mac_b    = beat ? in_b : '0;
    assign mac_bias = bias_q;
    assign out_data = res_q;
    assign busy     = (state != IDLE);

`ifdef MAC_SEQ_CTRL_RELU_EN
    assign cap_val = mac_acc[ACC_SIZE-1] ? '0 : mac_acc;
`else
    assign cap_val = mac_acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_load  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nx = BIAS;
                end
            end
            BIAS: begin
                mac_load = 1'b1;
                state_nx = (len_q == '0) ? CAP : ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && rem == LEN_W'(1)) begin
                    state_nx = CAP;
                end
            end
            CAP: begin
                state_nx = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Reset overrides everything and holds the MAC cleared.
        if (rst) begin
            state_nx  = IDLE;
            cmd_ready = 1'b0;
            in_ready  = 1'b0;
            out_valid = 1'b0;
            mac_load  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            rem    <= '0;
            bias_q <= '0;
            res_q  <= '0;
        end else begin
            if (cmd_fire) begin
                len_q  <= cmd_len;
                bias_q <= cmd_bias;
            end
            if (state == BIAS) begin
                rem <= len_q;
            end else if (beat) begin
                rem <= rem - LEN_W'(1);
            end
            if (state == CAP) begin
                res_q <= cap_val;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: scoreboard bench for mac_seq_ctrl with a MAC model.
// Expected dot products come from plain integer arithmetic on the job.
module tb_mac_seq_ctrl;

    localparam int VS = 8;
    localparam int AS = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic [AS-1:0] cmd_bias;
    logic          in_valid;
    logic          in_ready;
    logic [VS-1:0] in_a;
    logic [VS-1:0] in_b;
    logic [VS-1:0] mac_a;
    logic [VS-1:0] mac_b;
    logic [AS-1:0] mac_bias;
    logic          mac_load;
    logic [AS-1:0] mac_acc;
    logic          out_valid;
    logic          out_ready;
    logic [AS-1:0] out_data;
    logic          busy;

    always #5 clk = ~clk;

    mac_seq_ctrl #(.VAR_SIZE(VS), .ACC_SIZE(AS), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_bias(cmd_bias),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_bias(mac_bias),
        .mac_load(mac_load), .mac_acc(mac_acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // MAC environment model: load bias when mac_load, else add a*b.
    function automatic logic [AS-1:0] prod_ext(logic [VS-1:0] a, logic [VS-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p;
    endfunction

    logic [AS-1:0] acc_m = '0;
    always @(posedge clk) begin
        if (mac_load) acc_m <= mac_bias;
        else          acc_m <= acc_m + prod_ext(mac_a, mac_b);
    end
    assign mac_acc = acc_m;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    int ja[16];
    int jb[16];
    int jg[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=no_event required=event", name);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bounded wait expired");
    endtask

    function automatic int ref_result(int len, int bias);
        int r;
        r = bias;
        for (int i = 0; i < len; i++) r += ja[i] * jb[i];
`ifdef MAC_SEQ_CTRL_RELU_EN
        if (r < 0) r = 0;
`endif
        return r;
    endfunction

    // Scoreboard monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0d required=none",
                         $signed(out_data));
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("result", $signed(out_data), e);
            end
        end
    end

    task automatic wait_cmd_accept();
        int w;
        w = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            w++;
            if (w > 200) timeout("cmd_accept");
        end
    endtask

    task automatic run_job(int len, int bias, int hold);
        int acc_c, ov_c, w, gaps, ir_cnt;
        logic [AS-1:0] first;
        gaps = 0;
        for (int i = 0; i < len - 1; i++) gaps += jg[i];
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        cmd_bias  = bias;
        wait_cmd_accept();
        acc_c = cyc;
        exp_q.push_back(ref_result(len, bias));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_len   = LW'($urandom);
        cmd_bias  = $urandom;
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_a     = VS'(ja[i]);
            in_b     = VS'(jb[i]);
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 200) timeout("beat");
            end
            chk("mac_a_beat", $signed(mac_a), ja[i]);
            chk("mac_b_beat", $signed(mac_b), jb[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < len - 1) begin
                for (int g = 0; g < jg[i]; g++) begin
                    in_a = VS'($urandom);
                    in_b = VS'($urandom);
                    @(negedge clk);
                    chk("mac_a_gap", mac_a, 0);
                    chk("mac_b_gap", mac_b, 0);
                    @(posedge clk); #1;
                end
            end
        end
        in_a = VS'($urandom);
        in_b = VS'($urandom);
        w = 0;
        ir_cnt = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) ir_cnt++;
            w++;
            if (w > 200) timeout("out_valid");
        end
        ov_c = cyc;
        chk("in_ready_idle", ir_cnt, 0);
        chk("latency", ov_c - acc_c, len + 3 + gaps);
        first = out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, first);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hs_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, ov_cnt, len, hold;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = 16'd3;
        cmd_bias  = 32'd77;
        in_valid  = 1'b1;
        in_a      = 8'h35;
        in_b      = 8'h7a;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mac_load", mac_load, 1);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_out_data", out_data, 0);
        chk("post_rst_mac_bias", mac_bias, 0);
        chk("post_rst_mac_load", mac_load, 0);

        // basic job, back-to-back beats
        ja[0] = 2;  jb[0] = 3;
        ja[1] = -4; jb[1] = 5;
        ja[2] = 7;  jb[2] = -1;
        for (int i = 0; i < 16; i++) jg[i] = 0;
        run_job(3, 10, 0);

        // same job with 2-cycle gaps between beats
        jg[0] = 2;
        jg[1] = 2;
        run_job(3, 10, 0);

        // zero length
        run_job(0, -5, 0);

        // output stall
        jg[0] = 0;
        jg[1] = 0;
        ja[0] = -9; jb[0] = 11;
        ja[1] = 4;  jb[1] = 4;
        run_job(2, 1000, 5);

        // accumulator wrap
        ja[0] = 1; jb[0] = 1;
        run_job(1, 32'h7FFF_FFFF, 0);

        // reset mid-job after 2 of 4 beats
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = 16'd4;
        cmd_bias  = 32'd100;
        wait_cmd_accept();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 8'd5;
            in_b = 8'd6;
            w = 0;
            forever begin
                @(negedge clk);
                if (in_ready) break;
                w++;
                if (w > 200) timeout("abort_beat");
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("abort_mac_load", mac_load, 1);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_mac_a", mac_a, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_cmd_ready", cmd_ready, 1);
        ov_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_out_valid", ov_cnt, 0);
        ja[0] = 3; jb[0] = 4;
        run_job(1, 0, 0);

        // randomized jobs
        for (int j = 0; j < 25; j++) begin
            len  = $urandom_range(0, 6);
            hold = $urandom_range(0, 2);
            for (int i = 0; i < 16; i++) begin
                ja[i] = int'($urandom_range(0, 255)) - 128;
                jb[i] = int'($urandom_range(0, 255)) - 128;
                jg[i] = $urandom_range(0, 2);
            end
            run_job(len, int'($urandom), hold);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
